// File: rtl/st_encoder_sched.sv
// MSG3/MSG4 round-robin scheduler and byte-stream frame encoder with stall abort.
// Optional presence byte after the type byte when ST_ENCODER_PRESENCE_BYTE_EN is defined.
package st_encoder_pkg;

    typedef enum logic [7:0] {
        MSG_TYPE_MSG3 = 8'd4,
        MSG_TYPE_MSG4 = 8'd6
    } msg_type_supported_t;

    typedef struct packed {
        logic            field0_avail;
        logic [8:0][7:0] field0;
        logic            field1_avail;
        logic [2:0][7:0] field1;
        logic            z_avail;
        logic [5:0][7:0] z;
        logic            field2_avail;
        logic [4:0][7:0] field2;
        logic            field3_avail;
        logic [3:0][7:0] field3;
    } msg3_fields_t;

    typedef struct packed {
        logic            field0_avail;
        logic [8:0][7:0] field0;
        logic            field1_avail;
        logic [2:0][7:0] field1;
        logic            z_avail;
        logic [5:0][7:0] z;
        logic            field2_avail;
        logic [4:0][7:0] field2;
        logic            field3_avail;
        logic [2:0][7:0] field3;
    } msg4_fields_t;

endpackage

module st_encoder_sched
    import st_encoder_pkg::*;
#(
    parameter int unsigned STALL_LIMIT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         m3_valid,
    input  msg3_fields_t m3_msg,
    output logic         m3_ready,
    input  logic         m4_valid,
    input  msg4_fields_t m4_msg,
    output logic         m4_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_data,
    output logic         out_sop,
    output logic         out_eop,
    output logic         busy,
    output logic         grant_id,
    output logic         err_stall
);

    localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

    typedef enum logic [1:0] {IDLE, HDR, PRES, FIELD} state_t;

    state_t                state_reg, state_next;
    logic                  grant_reg, last_grant_reg, err_stall_reg;
    logic [4:0]            avail_reg, load_avail, after_mask;
    logic [4:0][8:0][7:0]  data_reg, load_data;
    logic [2:0]            fi_reg, fi_next, first_idx, nxt_idx;
    logic [3:0]            bi_reg, bi_next;
    logic [7:0]            stall_cnt_reg, stall_inc;
    logic                  grant_m3, grant_m4, accept, handshake, abort;
    logic                  first_found, nxt_found;

    // Lowest set bit wins: fields are emitted in ascending index order.
    function automatic logic [2:0] lowest(input logic [4:0] m);
        lowest = 3'd0;
        for (int i = 4; i >= 0; i--)
            if (m[i]) lowest = 3'(i);
    endfunction

    function automatic logic [3:0] last_byte(input logic [2:0] idx, input logic g);
        case (idx)
            3'd0:    last_byte = 4'd8;
            3'd1:    last_byte = 4'd2;
            3'd2:    last_byte = 4'd5;
            3'd3:    last_byte = 4'd4;
            default: last_byte = g ? 4'd2 : 4'd3;
        endcase
    endfunction

    for (genvar gi = 0; gi < 5; gi++) begin : g_after
        assign after_mask[gi] = avail_reg[gi] && (3'(gi) > fi_reg);
    end

    assign first_found = |avail_reg;
    assign first_idx   = lowest(avail_reg);
    assign nxt_found   = |after_mask;
    assign nxt_idx     = lowest(after_mask);

    // Ties go to whichever requester was not granted last.
    assign grant_m3 = rst_n && (state_reg == IDLE) && m3_valid && (!m4_valid || last_grant_reg);
    assign grant_m4 = rst_n && (state_reg == IDLE) && m4_valid && (!m3_valid || !last_grant_reg);
    assign accept   = grant_m3 || grant_m4;
    assign m3_ready = grant_m3;
    assign m4_ready = grant_m4;

    assign busy      = (state_reg != IDLE);
    assign grant_id  = grant_reg;
    assign err_stall = err_stall_reg;
    assign handshake = out_valid && out_ready;
    assign stall_inc = (stall_cnt_reg == 8'hFF) ? 8'hFF : stall_cnt_reg + 8'd1;

    always_comb begin
        load_data = '0;
        if (grant_m4) begin
            load_avail = {m4_msg.field3_avail, m4_msg.field2_avail, m4_msg.z_avail,
                          m4_msg.field1_avail, m4_msg.field0_avail};
            load_data[0]      = m4_msg.field0;
            load_data[1][2:0] = m4_msg.field1;
            load_data[2][5:0] = m4_msg.z;
            load_data[3][4:0] = m4_msg.field2;
            load_data[4][2:0] = m4_msg.field3;
        end else begin
            load_avail = {m3_msg.field3_avail, m3_msg.field2_avail, m3_msg.z_avail,
                          m3_msg.field1_avail, m3_msg.field0_avail};
            load_data[0]      = m3_msg.field0;
            load_data[1][2:0] = m3_msg.field1;
            load_data[2][5:0] = m3_msg.z;
            load_data[3][4:0] = m3_msg.field2;
            load_data[4][3:0] = m3_msg.field3;
        end
    end

    always_comb begin
        state_next = state_reg;
        fi_next    = fi_reg;
        bi_next    = bi_reg;
        out_valid  = 1'b0;
        out_sop    = 1'b0;
        out_eop    = 1'b0;
        out_data   = 8'd0;
        abort      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = HDR;
            end
            HDR: begin
                out_valid = 1'b1;
                out_sop   = 1'b1;
                out_data  = grant_reg ? MSG_TYPE_MSG4 : MSG_TYPE_MSG3;
`ifdef ST_ENCODER_PRESENCE_BYTE_EN
                if (handshake) state_next = PRES;
            end
            PRES: begin
                out_valid = 1'b1;
                out_data  = {3'b000, avail_reg};
`endif
                out_eop = !first_found;
                if (handshake) begin
                    if (first_found) begin
                        state_next = FIELD;
                        fi_next    = first_idx;
                        bi_next    = last_byte(first_idx, grant_reg);
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            FIELD: begin
                out_valid = 1'b1;
                out_data  = data_reg[fi_reg][bi_reg];
                out_eop   = (bi_reg == 4'd0) && !nxt_found;
                if (handshake) begin
                    if (bi_reg != 4'd0) begin
                        bi_next = bi_reg - 4'd1;
                    end else if (nxt_found) begin
                        fi_next = nxt_idx;
                        bi_next = last_byte(nxt_idx, grant_reg);
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // The stall that brings the counter to the limit ends the frame without eop.
        if (out_valid && !out_ready && (LIMIT != 8'd0) && (stall_inc >= LIMIT)) begin
            abort      = 1'b1;
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            err_stall_reg  <= 1'b0;
            avail_reg      <= '0;
            fi_reg         <= '0;
            bi_reg         <= '0;
            stall_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            fi_reg        <= fi_next;
            bi_reg        <= bi_next;
            err_stall_reg <= abort;
            if (accept) begin
                grant_reg      <= grant_m4;
                last_grant_reg <= grant_m4;
                avail_reg      <= load_avail;
            end
            if ((state_reg == IDLE) || handshake || abort)
                stall_cnt_reg <= '0;
            else if (out_valid && !out_ready)
                stall_cnt_reg <= stall_inc;
        end
    end

    // Payload bytes carry no reset; they are only visible after an accept loads them.
    always_ff @(posedge clk) begin
        if (accept) data_reg <= load_data;
    end

endmodule

// File: doc/st_encoder_sched.md
ST_ENCODER_SCHED -- requirements
Module: st_encoder_sched

Interface
REQ-001 Parameter STALL_LIMIT, default 255, max consecutive stalled output cycles before frame abort; 0 disables the abort.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 m3_valid  input  1  MSG3 request pending.
REQ-005 m3_msg  input  MSG3_fields  MSG3 field content; sampled only on accept.
REQ-006 m3_ready  output  1  MSG3 request accepted this cycle.
REQ-007 m4_valid / m4_msg / m4_ready  same as REQ-004..006 for MSG4 (MSG4_fields).
REQ-008 out_valid  output  1  out_data holds a valid byte.
REQ-009 out_ready  input  1  downstream accepts the byte.
REQ-010 out_data  output  8  encoded stream byte.
REQ-011 out_sop / out_eop  output  1 each  first / last byte of the frame, qualified by out_valid.
REQ-012 busy  output  1  a frame is in progress (state != IDLE).
REQ-013 grant_id  output  1  0 = MSG3 frame, 1 = MSG4 frame; valid while busy.
REQ-014 err_stall  output  1  one-cycle pulse on stall abort.

Function
REQ-015 States: IDLE, HDR, PRES (REQ-033 only), FIELD.
REQ-016 In IDLE, one requester is granted per cycle: a sole valid wins; if both are valid, the one not granted last wins (round-robin).
REQ-017 The x_ready of the winner is high for exactly one cycle, combinationally in IDLE; the loser's ready stays low.
REQ-018 On accept, the full struct is registered and grant_id is set; the next state is HDR.
REQ-019 The type byte appears on out_data one cycle after accept: 8'd4 for MSG3 (msg_type_supported_t), 8'd6 for MSG4, with out_sop=1.
REQ-020 Field order: field0, field1, Z, field2, field3.
REQ-021 Sizes: 9, 3, 6, 5 bytes, then field3 = 4 bytes (MSG3) or 3 bytes (MSG4).
REQ-022 Fields with *_avail=0 are skipped with zero bubble cycles.
REQ-023 Within a field, bytes go highest index first (field0[8] ... field0[0]).
REQ-024 Each byte is held stable (data, sop, eop) while out_valid && !out_ready.
REQ-025 Advance on out_valid && out_ready only; no bubbles between bytes.
REQ-026 out_eop=1 on the last byte of the frame. If no field is available, the type byte carries both sop and eop.
REQ-027 After the eop handshake the state returns to IDLE, and out_valid=0 that cycle. The earliest next accept is the following cycle.
REQ-028 Frame length: MSG3 all fields = 28 bytes; MSG4 all fields = 27 bytes; plus 1 byte if REQ-033 is enabled.
REQ-029 Stall counter (8 bits, saturating):
- increments on each out_valid && !out_ready cycle;
- clears on handshake or in IDLE.
REQ-030 When the stall counter reaches STALL_LIMIT (nonzero), the frame is aborted: the next cycle shows out_valid=0, err_stall=1, state IDLE; the frame has no eop.
REQ-031 A requester deasserting valid while not granted is legal; it is simply not accepted.

Reset
REQ-032 While rst_n=0 at a clock edge:
- state IDLE; out_valid, out_sop, out_eop, out_data, busy, err_stall, m3_ready, m4_ready = 0;
- grant_id = 0; last-granted = MSG4, so MSG3 wins the first tie;
- stall counter cleared; any frame in progress is dropped with no eop.

Configuration
REQ-033 Macro ST_ENCODER_PRESENCE_BYTE_EN:
- Defined: a presence byte {3'b0, field3_avail, field2_avail, Z_avail, field1_avail, field0_avail} follows the type byte (state PRES). It carries eop if no field is available.
- Undefined: PRES is absent and fields directly follow the type byte.

Verification
REQ-034 MSG3 alone, all avail, out_ready=1 -> 28 contiguous bytes starting 8'd4 with sop, field0[8] second, field3[0] last with eop; first byte one cycle after accept.
REQ-035 m3_valid and m4_valid both held for 3 frames from reset -> grant order MSG3, MSG4, MSG3; each ready is a single-cycle pulse.
REQ-036 MSG4, only Z_avail=1 -> 7 bytes: 8'd6 then Z[5]..Z[0], eop on Z[0] (8 bytes with presence byte 8'h04 when macro defined).
REQ-037 MSG3, no avail, out_ready toggling 1/0 -> single byte 8'd4 with sop and eop, held stable through stall cycles.
REQ-038 STALL_LIMIT=4, out_ready=0 after 2 bytes -> after 4 stalled cycles: out_valid=0, err_stall one-cycle pulse, busy=0; the next request is accepted normally.
REQ-039 rst_n=0 for one cycle mid-frame -> all outputs at REQ-032 values the next cycle; no eop emitted; MSG3 wins the next tie.
